// File: rtl/ssg_emb_sd_adc_sinc3_decim_if.sv
// rtl/ssg_emb_sd_adc_sinc3_decim_if.sv - control, bitstream and sample bundle of the sinc3 decimator
interface ssg_emb_sd_adc_sinc3_decim_if #(
  parameter int OUT_W = 16
);
  logic             enable;
  logic             sd_data;
  logic [3:0]       dec_log2;
  logic [OUT_W-1:0] offset;
  logic [OUT_W-1:0] sample;
  logic             sample_valid;
  logic             sat_flag;
  logic             settling;

  modport master (
    output enable, sd_data, dec_log2, offset,
    input  sample, sample_valid, sat_flag, settling
  );

  modport slave (
    input  enable, sd_data, dec_log2, offset,
    output sample, sample_valid, sat_flag, settling
  );
endinterface

// File: rtl/ssg_emb_sd_adc_sinc3_decim.sv
// rtl/ssg_emb_sd_adc_sinc3_decim.sv - sinc3 CIC decimator for a 1-bit sigma-delta stream
module ssg_emb_sd_adc_sinc3_decim #(
  parameter int OUT_W        = 16,
  parameter int MIN_DEC_LOG2 = 4,
  parameter int MAX_DEC_LOG2 = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  ssg_emb_sd_adc_sinc3_decim_if.slave   bus
);
  localparam int ACC_W = 3 * MAX_DEC_LOG2 + 1;
  localparam int CNT_W = MAX_DEC_LOG2;
  localparam logic signed [OUT_W+1:0] HALF    = (OUT_W+2)'(2 ** (OUT_W - 1));
  localparam logic signed [OUT_W+1:0] POS_MAX = (OUT_W+2)'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [OUT_W+1:0] NEG_MIN = -POS_MAX;

  logic [3:0]              l_req;
  logic [3:0]              active_l;
  logic                    restart;
  logic                    run;
  logic                    dec_event;
  logic [CNT_W-1:0]        dec_mask;
  logic [CNT_W-1:0]        cnt;
  logic [ACC_W-1:0]        i1, i2, i3;
  logic [ACC_W-1:0]        z0, z1, z2;
  logic [ACC_W-1:0]        c1, c2, raw, x_aligned;
  logic [7:0]              shamt;
  logic [OUT_W:0]          u;
  logic signed [OUT_W+1:0] off_ext;
  logic signed [OUT_W+1:0] d;
  logic [OUT_W-1:0]        sample_next;
  logic                    sat_next;
  logic [1:0]              settle_cnt;
  logic [OUT_W-1:0]        sample_q;
  logic                    valid_q;
  logic                    sat_q;
  logic                    settling_q;

  always_comb begin
    l_req = bus.dec_log2;
    if (bus.dec_log2 < 4'(MIN_DEC_LOG2)) begin
      l_req = 4'(MIN_DEC_LOG2);
    end else if (bus.dec_log2 > 4'(MAX_DEC_LOG2)) begin
      l_req = 4'(MAX_DEC_LOG2);
    end
  end

  // a rate change while running restarts the filter in the same cycle
  assign restart   = bus.enable && (l_req != active_l);
  assign run       = bus.enable && !restart;
  assign dec_mask  = CNT_W'((32'd1 << active_l) - 32'd1);
  assign dec_event = run && (cnt == dec_mask);

  assign c1  = i3 - z0;
  assign c2  = c1 - z1;
  assign raw = c2 - z2;

  // left-align so that full scale M^3 always lands on bit ACC_W-1
  assign shamt     = 8'(3 * (MAX_DEC_LOG2 - int'(active_l)));
  assign x_aligned = raw << shamt;
  assign u         = (OUT_W+1)'(x_aligned >> (ACC_W - OUT_W - 1));
  assign off_ext   = $signed({{2{bus.offset[OUT_W-1]}}, bus.offset});
  assign d         = $signed({1'b0, u}) - HALF - off_ext;

  always_comb begin
    sample_next = d[OUT_W-1:0];
    sat_next    = 1'b0;
    if (d > POS_MAX) begin
      sample_next = POS_MAX[OUT_W-1:0];
      sat_next    = 1'b1;
    end else if (d < NEG_MIN) begin
      sample_next = NEG_MIN[OUT_W-1:0];
      sat_next    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_l <= 4'(MIN_DEC_LOG2);
    end else begin
      active_l <= l_req;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      i1         <= '0;
      i2         <= '0;
      i3         <= '0;
      z0         <= '0;
      z1         <= '0;
      z2         <= '0;
      settle_cnt <= '0;
    end else if (!run) begin
      cnt        <= '0;
      i1         <= '0;
      i2         <= '0;
      i3         <= '0;
      z0         <= '0;
      z1         <= '0;
      z2         <= '0;
      settle_cnt <= '0;
    end else begin
      i1  <= i1 + ACC_W'(bus.sd_data);
      i2  <= i2 + i1;
      i3  <= i3 + i2;
      cnt <= dec_event ? '0 : cnt + 1'b1;
      if (dec_event) begin
        z0 <= i3;
        z1 <= c1;
        z2 <= c2;
        if (settle_cnt != 2'd3) begin
          settle_cnt <= settle_cnt + 2'd1;
        end
      end
    end
  end

  // sample and sat_flag survive clears; only a strobe or reset changes them
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_q   <= '0;
      valid_q    <= 1'b0;
      sat_q      <= 1'b0;
      settling_q <= 1'b1;
    end else begin
      valid_q <= 1'b0;
      if (!run) begin
        settling_q <= 1'b1;
      end else if (dec_event && (settle_cnt == 2'd3)) begin
        valid_q    <= 1'b1;
        sample_q   <= sample_next;
        sat_q      <= sat_next;
        settling_q <= 1'b0;
      end
    end
  end

  assign bus.sample       = sample_q;
  assign bus.sample_valid = valid_q;
  assign bus.sat_flag     = sat_q;
  assign bus.settling     = settling_q;
endmodule

// File: tb/tb_ssg_emb_sd_adc_sinc3_decim.sv
// tb/tb_ssg_emb_sd_adc_sinc3_decim.sv - scoreboard bench for the sinc3 decimator
module tb_ssg_emb_sd_adc_sinc3_decim;
  localparam int MIN_L = 4;
  localparam int MAX_L = 8;
  localparam longint ACC_MASK = (64'd1 << 25) - 1;

  typedef struct {
    logic [15:0] s;
    logic        sat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ssg_emb_sd_adc_sinc3_decim_if #(.OUT_W(16)) bus ();

  ssg_emb_sd_adc_sinc3_decim #(
    .OUT_W(16), .MIN_DEC_LOG2(MIN_L), .MAX_DEC_LOG2(MAX_L)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          hist[$];
  exp_t        sb[$];
  int          m_l = MIN_L;
  int          m_cnt = 0;
  int          m_settle = 0;
  bit          m_settling = 1'b1;
  logic [15:0] m_sample = '0;
  logic        m_sat = 1'b0;
  bit          phase = 1'b1;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // i3 before the update of cycle t is sum of x_j * C(t-1-j, 2)
  function automatic longint i3_at(int t);
    longint acc = 0;
    for (int j = 0; j < t && j < hist.size(); j++) begin
      if (hist[j]) acc += longint'(t - 1 - j) * longint'(t - 2 - j) / 2;
    end
    return acc;
  endfunction

  function automatic int clamp_l(int dl);
    return (dl < MIN_L) ? MIN_L : (dl > MAX_L) ? MAX_L : dl;
  endfunction

  task automatic step(input bit en, input bit sd, input int dl, input logic [15:0] off);
    int     lreq, mm, te;
    longint r, x, u, dd;
    exp_t   e;
    bit     strobe = 1'b0;
    bus.enable   = en;
    bus.sd_data  = sd;
    bus.dec_log2 = 4'(dl);
    bus.offset   = off;
    lreq = clamp_l(dl);
    if (!en || lreq != m_l) begin
      hist.delete();
      m_cnt = 0;
      m_settle = 0;
      m_settling = 1'b1;
    end else begin
      mm = 1 << m_l;
      if (m_cnt == mm - 1) begin
        if (m_settle < 3) begin
          m_settle++;
        end else begin
          te = hist.size();
          r  = (i3_at(te) - 3 * i3_at(te - mm) + 3 * i3_at(te - 2 * mm) - i3_at(te - 3 * mm)) & ACC_MASK;
          x  = (r << (3 * (MAX_L - m_l))) & ACC_MASK;
          u  = x >> 8;
          dd = u - 32768 - longint'($signed(off));
          if (dd > 32767) begin
            e.s = 16'h7FFF; e.sat = 1'b1;
          end else if (dd < -32767) begin
            e.s = 16'h8001; e.sat = 1'b1;
          end else begin
            e.s = 16'(dd); e.sat = 1'b0;
          end
          sb.push_back(e);
          strobe = 1'b1;
          m_settling = 1'b0;
        end
      end
      hist.push_back(sd);
      m_cnt = (m_cnt + 1) % mm;
    end
    m_l = lreq;
    @(posedge clk);
    #1;
    check_eq("valid", bus.sample_valid, strobe);
    if (bus.sample_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_strobe", 1, 0);
      end else begin
        e = sb.pop_front();
        check_eq("sample", bus.sample, e.s);
        check_eq("sat_flag", bus.sat_flag, e.sat);
        m_sample = e.s;
        m_sat = e.sat;
      end
    end
    if (sb.size() != 0) begin
      check_eq("missed_strobe", sb.size(), 0);
      sb.delete();
    end
    check_eq("hold_sample", bus.sample, m_sample);
    check_eq("hold_sat", bus.sat_flag, m_sat);
    check_eq("settling", bus.settling, m_settling);
  endtask

  task automatic run_alt(input int n, input int dl, input logic [15:0] off);
    for (int i = 0; i < n; i++) begin
      step(1'b1, phase, dl, off);
      phase = ~phase;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.enable = 1'b0;
    reset = 1'b1;
    #1;
    check_eq("rst_sample", bus.sample, 16'h0000);
    check_eq("rst_valid", bus.sample_valid, 1'b0);
    check_eq("rst_sat", bus.sat_flag, 1'b0);
    check_eq("rst_settling", bus.settling, 1'b1);
    hist.delete();
    m_l = MIN_L; m_cnt = 0; m_settle = 0; m_settling = 1'b1;
    m_sample = '0; m_sat = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [15:0] held;
  int          guard;

  initial begin
    bus.enable = 1'b0; bus.sd_data = 1'b0; bus.dec_log2 = 4'd7; bus.offset = '0;
    reset = 1'b0;
    do_reset();

    // idle two cycles at L=7 so the rising enable is counter cycle 0
    step(1'b0, 1'b0, 7, 16'h0000);
    step(1'b0, 1'b0, 7, 16'h0000);
    phase = 1'b1;
    run_alt(511, 7, 16'h0000);
    check_eq("first_strobe_not_early", bus.sample_valid, 1'b0);
    run_alt(1, 7, 16'h0000);
    check_eq("first_strobe_512", bus.sample_valid, 1'b1);
    check_eq("alt_sample", bus.sample, 16'h0000);
    check_eq("alt_sat", bus.sat_flag, 1'b0);
    check_eq("alt_settled", bus.settling, 1'b0);
    run_alt(488, 7, 16'h0000);

    run_alt(600, 7, 16'h0010);
    check_eq("offset_sample", bus.sample, 16'hFFF0);

    run_alt(100, 7, 16'h0000);
    run_alt(300, 5, 16'h0000);
    check_eq("rate5_sample", bus.sample, 16'h0000);
    run_alt(1100, 12, 16'h0000);
    check_eq("rate12_sample", bus.sample, 16'h0000);

    for (int i = 0; i < 700; i++) step(1'b1, 1'b1, 7, 16'h0000);
    check_eq("const1_sample", bus.sample, 16'h7FFF);
    check_eq("const1_sat", bus.sat_flag, 1'b1);
    for (int i = 0; i < 700; i++) step(1'b1, 1'b0, 7, 16'h0000);
    check_eq("const0_sample", bus.sample, 16'h8001);
    check_eq("const0_sat", bus.sat_flag, 1'b1);

    run_alt(600, 7, 16'h0000);
    guard = 0;
    while (m_cnt != (1 << m_l) - 1 && guard < 300) begin
      run_alt(1, 7, 16'h0000);
      guard++;
    end
    check_eq("event_found", guard < 300, 1'b1);
    held = bus.sample;
    step(1'b0, 1'b0, 7, 16'h0000);
    check_eq("en_drop_valid", bus.sample_valid, 1'b0);
    check_eq("en_drop_hold", bus.sample, held);
    check_eq("en_drop_settling", bus.settling, 1'b1);
    run_alt(600, 7, 16'h0000);

    run_alt(300, 7, 16'h0000);
    do_reset();
    check_eq("rst_mid_sample", bus.sample, 16'h0000);
    step(1'b0, 1'b0, 7, 16'h0000);
    run_alt(600, 7, 16'h0000);

    for (int l = MIN_L; l <= MAX_L; l++) begin
      int          dl;
      logic [15:0] off;
      dl  = (l == MIN_L) ? 2 : (l == MAX_L) ? 15 : l;
      off = 16'($urandom_range(0, 2047)) - 16'd1024;
      for (int i = 0; i < (5 << l) + 3; i++) begin
        step(1'b1, ($urandom_range(0, 3) != 0) ^ (l[0]), dl, off);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ssg_emb_sd_adc_sinc3_decim.md
SSG_EMB_SD_ADC_SINC3_DECIM -- requirements
Module: ssg_emb_sd_adc_sinc3_decim

Interface
REQ-001 Parameter OUT_W, default 16: width of the output sample in bits.
REQ-002 Parameter MIN_DEC_LOG2, default 4: smallest supported log2 of the decimation ratio M.
REQ-003 Parameter MAX_DEC_LOG2, default 8: largest supported log2 of M.
REQ-004 Derived ACC_W = 3*MAX_DEC_LOG2+1: width of the integrator and differentiator datapath.
REQ-005 clk  in  1: modulator clock; the single clock domain; all logic on the rising edge.
REQ-006 reset  in  1: asynchronous, active-high reset.
REQ-007 enable  in  1: filter run; 0 holds the filter cleared.
REQ-008 sd_data  in  1: sigma-delta bitstream, synchronous to clk, sampled every enabled cycle.
REQ-009 dec_log2  in  4: requested log2(M).
REQ-010 offset  in  OUT_W: signed zero-offset correction.
REQ-011 sample  out  OUT_W: signed two's-complement filtered sample.
REQ-012 sample_valid  out  1: one-cycle strobe marking a new sample.
REQ-013 sat_flag  out  1: the sample presented with the current or last strobe was clamped.
REQ-014 settling  out  1: the filter is cleared or filling; no valid output yet.

Function
REQ-015 Active rate L SHALL be dec_log2 clamped to [MIN_DEC_LOG2, MAX_DEC_LOG2], and M SHALL be 2^L.
REQ-016 Three cascaded integrators SHALL operate modulo 2^ACC_W on every enabled cycle: i1+=sd_data, i2+=i1, i3+=i2.
REQ-017 A decimation counter SHALL count 0..M-1 on enabled cycles and wrap; the terminal count is the decimation event.
REQ-018 At each event, three differentiator stages SHALL register i3 and its first and second differences; the third difference is raw (ACC_W bits, modulo).
REQ-019 raw SHALL be left-aligned as x = raw << 3*(MAX_DEC_LOG2-L), so that full scale M^3 maps to 2^(ACC_W-1).
REQ-020 u SHALL be x[ACC_W-1 -: OUT_W+1], unsigned, in the range 0..2^OUT_W.
REQ-021 d SHALL be u - 2^(OUT_W-1) - signed(offset), computed in OUT_W+2 signed bits with no wrap.
REQ-022 A d above 2^(OUT_W-1)-1 SHALL clamp to 2^(OUT_W-1)-1 (0x7FFF); a d below -(2^(OUT_W-1)-1) SHALL clamp to 0x8001. Either clamp sets sat_flag with that sample, otherwise sat_flag clears.
REQ-023 sample, sat_flag and sample_valid SHALL update in the cycle after the event, giving an event-to-strobe latency of 1 clk.
REQ-024 offset SHALL be sampled at output computation and take effect on the next strobe.
REQ-025 sample and sat_flag SHALL hold between strobes.
REQ-026 The first 3 events after a clear SHALL be suppressed: no strobe, sample held, settling=1. settling SHALL fall together with the first strobe, on the 4th event+1.
REQ-027 A clear (enable=0, or a restart) SHALL zero the integrators, counter, differentiators and the settle count, set settling=1, and keep sample and sat_flag.
REQ-028 The clamped dec_log2 SHALL be compared with the active L every cycle; a mismatch while enabled causes a restart that cycle, and the new L applies from the next cycle as counter cycle 0.
REQ-029 If enable falls in the same cycle as an event, the clear SHALL win, and no strobe follows.
REQ-030 The first enabled cycle after a clear SHALL be counter cycle 0, so events fall on cycles kM-1 and strobes on cycles kM.

Reset
REQ-031 While reset=1, all registers SHALL clear asynchronously: sample=0, sample_valid=0, sat_flag=0, settling=1, integrators/counter/differentiators=0, active L=MIN_DEC_LOG2.
REQ-032 After reset deasserts, behaviour SHALL be identical to a clear; a reset asserted mid-frame SHALL abort without a strobe.

Verification
REQ-033 Defaults; dec_log2=7; enable rises at cycle 0; sd_data alternating 1,0 from cycle 0 -> first strobe at cycle 512, settling falls at 512, sample=0x0000, sat_flag=0; strobes every 128 cycles.
REQ-034 Same as REQ-033 but offset=0x0010 -> sample=0xFFF0 on every post-settle strobe.
REQ-035 sd_data constant 1 with dec_log2=7 -> sample=0x7FFF, sat_flag=1; sd_data constant 0 -> sample=0x8001, sat_flag=1.
REQ-036 Alternating stream with dec_log2 changed 7->5 at cycle 700 -> settling=1 from cycle 700, no strobe until cycle 700+128, then sample=0x0000; dec_log2=12 -> behaves as L=8.
REQ-037 enable dropped in an event cycle, and reset pulsed mid-frame -> no strobe, sample held (enable) or 0 (reset), settling=1, and the restart timing of REQ-033.
REQ-038 Random bitstreams at L=4..8 -> each sample matches a bit-true sinc3 reference model including clamp and sat_flag.
